// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types, widths and helpers for the pipeline stall
//               controller and its statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        HALTED   = 2'd3
    } stall_state_t;

    // Encoding of the NOP loaded into a flushed pipeline register (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int c_flush_cnt_w = 3;
    localparam int c_wait_cnt_w  = 8;
    localparam int c_stat_cnt_w  = 16;

    function automatic logic [c_wait_cnt_w-1:0] sat_inc_wait(input logic [c_wait_cnt_w-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_stat_counters.sv
`default_nettype none
// ============================================================================
// Module      : stall_stat_counters
// Description : Bank of saturating event counters, one per increment strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_stat_counters
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_CNT = 3,
    parameter int CNT_W   = c_stat_cnt_w
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CNT-1:0]       inc,
    output logic [NUM_CNT*CNT_W-1:0] cnt
);

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (inc[i] && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign cnt[i*CNT_W +: CNT_W] = r_cnt;
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Turns load-use, branch, memory-wait and halt requests into
//               per-stage write/flush/bubble controls. Optional statistics
//               counters are built when STALL_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_use_stall,
    input  logic        branch_taken,
    input  logic        mem_busy,
    input  logic        halt_req,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_mem_write,
    output logic        done,
    output logic        mem_timeout
`ifdef STALL_STATS_EN
    ,
    output logic [15:0] load_stall_cnt,
    output logic [15:0] flush_cnt_total,
    output logic [15:0] mem_wait_cnt
`endif
);

    localparam logic [c_flush_cnt_w-1:0] c_flush_reload = c_flush_cnt_w'(FLUSH_CYCLES - 1);
    localparam logic [c_wait_cnt_w-1:0]  c_mem_timeout  = c_wait_cnt_w'(MEM_TIMEOUT);
    localparam logic [c_wait_cnt_w-1:0]  c_wait_first   = c_wait_cnt_w'(1);
    localparam logic                     c_multi_flush  = (FLUSH_CYCLES > 1);

    stall_state_t              r_state;
    stall_state_t              w_state_nxt;
    logic [c_flush_cnt_w-1:0]  r_flush_cnt;
    logic [c_flush_cnt_w-1:0]  w_flush_cnt_nxt;
    logic [c_wait_cnt_w-1:0]   r_wait_cnt;
    logic [c_wait_cnt_w-1:0]   w_wait_cnt_nxt;
    logic                      r_mem_timeout;
    logic                      w_timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_flush_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_mem_timeout <= r_mem_timeout | w_timeout_hit;
        end
    end

    assign mem_timeout = r_mem_timeout;

    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        ex_mem_write    = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        done            = 1'b0;
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_timeout_hit   = 1'b0;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else begin
            case (r_state)
                // The first ready cycle after a memory wait behaves exactly like RUN.
                RUN, MEM_WAIT: begin
                    if (mem_busy) begin
                        pc_write       = 1'b0;
                        if_id_write    = 1'b0;
                        ex_mem_write   = 1'b0;
                        w_state_nxt    = MEM_WAIT;
                        w_wait_cnt_nxt = (r_state == RUN) ? c_wait_first : sat_inc_wait(r_wait_cnt);
                        w_timeout_hit  = (w_wait_cnt_nxt >= c_mem_timeout);
                    end else begin
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = RUN;
                        if (branch_taken) begin
                            if_id_flush  = 1'b1;
                            id_ex_bubble = 1'b1;
                            if (c_multi_flush) begin
                                w_state_nxt     = FLUSH;
                                w_flush_cnt_nxt = c_flush_reload;
                            end
                        end else if (load_use_stall) begin
                            pc_write     = 1'b0;
                            if_id_write  = 1'b0;
                            id_ex_bubble = 1'b1;
                        end else if (halt_req) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            w_state_nxt = HALTED;
                        end
                    end
                end

                // Instructions seen here are on the wrong path, so stall and halt requests are dropped.
                FLUSH: begin
                    if (mem_busy) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        ex_mem_write = 1'b0;
                    end else begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (branch_taken) begin
                            w_flush_cnt_nxt = c_flush_reload;
                        end else begin
                            w_flush_cnt_nxt = r_flush_cnt - 1'b1;
                            if (w_flush_cnt_nxt == '0) begin
                                w_state_nxt = RUN;
                            end
                        end
                    end
                end

                HALTED: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    done         = 1'b1;
                end

                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

`ifdef STALL_STATS_EN
    logic [2:0]                w_stat_inc;
    logic [3*c_stat_cnt_w-1:0] w_stat_cnt;

    assign w_stat_inc[0] = id_ex_bubble & ~if_id_flush;
    assign w_stat_inc[1] = if_id_flush;
    assign w_stat_inc[2] = ~reset & mem_busy & (r_state != HALTED);

    stall_stat_counters #(
        .NUM_CNT (3),
        .CNT_W   (c_stat_cnt_w)
    ) u_stall_stat_counters (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stat_inc),
        .cnt   (w_stat_cnt)
    );

    assign load_stall_cnt  = w_stat_cnt[0*c_stat_cnt_w +: c_stat_cnt_w];
    assign flush_cnt_total = w_stat_cnt[1*c_stat_cnt_w +: c_stat_cnt_w];
    assign mem_wait_cnt    = w_stat_cnt[2*c_stat_cnt_w +: c_stat_cnt_w];
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Randomized scoreboard bench for pipeline_stall_ctrl against a
//               cycle-level behavioural model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    localparam int FLUSH_CYCLES = 3;
    localparam int MEM_TIMEOUT  = 5;
    localparam int NUM_CYCLES   = 4000;

    logic clk = 1'b0;
    logic reset;
    logic load_use_stall;
    logic branch_taken;
    logic mem_busy;
    logic halt_req;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic done;
    logic mem_timeout;
`ifdef STALL_STATS_EN
    logic [15:0] load_stall_cnt;
    logic [15:0] flush_cnt_total;
    logic [15:0] mem_wait_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MEM_TIMEOUT  (MEM_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .halt_req       (halt_req),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_write   (ex_mem_write),
        .done           (done),
        .mem_timeout    (mem_timeout)
`ifdef STALL_STATS_EN
        ,
        .load_stall_cnt  (load_stall_cnt),
        .flush_cnt_total (flush_cnt_total),
        .mem_wait_cnt    (mem_wait_cnt)
`endif
    );

    // outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, done, mem_timeout}
    typedef struct packed {
        logic [6:0]  outs;
        logic [47:0] stats;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model: what the pipeline is currently doing, in plain terms.
    bit m_halted;
    bit m_timeout;
    int m_flush_left;   // flush cycles still owed after the current one
    int m_busy_streak;  // consecutive busy cycles seen outside a flush
    int m_load_stalls;
    int m_flushes;
    int m_frozen;
    int m_event;        // 0 none, 1 load stall, 2 flush, 3 frozen

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic [4:0] ctl;
        m_event = 0;
        if (reset)                                ctl = 5'b00000;
        else if (m_halted)                        ctl = 5'b00000;
        else if (mem_busy)       begin ctl = 5'b00000; m_event = 3; end
        else if (branch_taken || m_flush_left > 0) begin ctl = 5'b11111; m_event = 2; end
        else if (load_use_stall) begin ctl = 5'b00011; m_event = 1; end
        else if (halt_req)                        ctl = 5'b00001;
        else                                      ctl = 5'b11001;
        e.outs  = {ctl, (!reset && m_halted), m_timeout};
        e.stats = {m_load_stalls[15:0], m_flushes[15:0], m_frozen[15:0]};
        return e;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_halted = 0; m_timeout = 0; m_flush_left = 0; m_busy_streak = 0;
            m_load_stalls = 0; m_flushes = 0; m_frozen = 0;
        end else begin
            if (m_event == 1) m_load_stalls = sat16(m_load_stalls);
            if (m_event == 2) m_flushes     = sat16(m_flushes);
            if (m_event == 3) m_frozen      = sat16(m_frozen);
            if (m_halted) begin
                // only reset leaves the halted state
            end else if (mem_busy) begin
                if (m_flush_left == 0) begin
                    m_busy_streak = (m_busy_streak >= 255) ? 255 : m_busy_streak + 1;
                    if (m_busy_streak >= MEM_TIMEOUT) m_timeout = 1;
                end
            end else begin
                m_busy_streak = 0;
                if (branch_taken)           m_flush_left = FLUSH_CYCLES - 1;
                else if (m_flush_left > 0)  m_flush_left = m_flush_left - 1;
                else if (load_use_stall)    m_flush_left = 0;
                else if (halt_req)          m_halted = 1;
            end
        end
    endtask

    initial begin
        int burst_left;
        exp_t e;
        burst_left     = 0;
        reset          = 1'b1;
        load_use_stall = 1'b0;
        branch_taken   = 1'b0;
        mem_busy       = 1'b0;
        halt_req       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_halted = 0; m_timeout = 0; m_flush_left = 0; m_busy_streak = 0;
        m_load_stalls = 0; m_flushes = 0; m_frozen = 0; m_event = 0;

        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            if (cyc > 0) begin
                reset = ($urandom_range(0, 99) < 2);
                if (burst_left == 0 && $urandom_range(0, 99) < 8)
                    burst_left = $urandom_range(1, 9);
                mem_busy = (burst_left > 0);
                if (burst_left > 0) burst_left--;
                branch_taken   = ($urandom_range(0, 99) < 12);
                load_use_stall = ($urandom_range(0, 99) < 20);
                halt_req       = ($urandom_range(0, 99) < 2);
            end
            e = predict();
            exp_q.push_back(e);
            @(posedge clk);
            model_step();
            #1;
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        exp_t       e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, done, mem_timeout};
                vectors++;
                if (got !== e.outs) begin
                    miscompares++;
                    $display("FAIL ctrl_outs t=%0t got=%b required=%b (pc,ifid_w,flush,bubble,exmem_w,done,timeout)",
                             $time, got, e.outs);
                end
`ifdef STALL_STATS_EN
                vectors++;
                if ({load_stall_cnt, flush_cnt_total, mem_wait_cnt} !== e.stats) begin
                    miscompares++;
                    $display("FAIL stats t=%0t got=%0d/%0d/%0d required=%0d/%0d/%0d", $time,
                             load_stall_cnt, flush_cnt_total, mem_wait_cnt,
                             e.stats[47:32], e.stats[31:16], e.stats[15:0]);
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central pipeline-control responder that consumes the hazard requests raised around the 5-stage pipeline: load-use stall, taken branch, data-memory wait and halt. It converts them into per-stage write-enable, flush and bubble controls. A registered FSM handles multi-cycle flushes, memory wait with timeout, and halt. It sits beside the hazard detector and drives the PC, IF/ID, ID/EX and EX/MEM register controls.

Parameters:
FLUSH_CYCLES, 1, cycles of fetch flush per taken branch (1..7)
MEM_TIMEOUT, 64, max consecutive mem_busy cycles before mem_timeout (1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load_use_stall  input  1  load-use hazard request from hazard detector
branch_taken  input  1  branch in EX resolved taken
mem_busy  input  1  data memory not ready this cycle
halt_req  input  1  halt instruction in EX
pc_write  output  1  PC register update enable
if_id_write  output  1  IF/ID register update enable
if_id_flush  output  1  IF/ID loads NOP
id_ex_bubble  output  1  ID/EX loads NOP (control bits zeroed)
ex_mem_write  output  1  EX/MEM register update enable
done  output  1  processor halted
mem_timeout  output  1  sticky error, memory wait exceeded MEM_TIMEOUT

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Output timing: outputs are combinational from the registered state, the counters and the current inputs. State and counters update on clk.
- Reset: state=RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0. While reset is high, pc_write, if_id_write and ex_mem_write are 0, and flush, bubble and done are 0. Reset mid-flush or mid-wait aborts to RUN.
- Default (RUN, no request): pc_write=if_id_write=ex_mem_write=1; if_id_flush=id_ex_bubble=done=0.
- Priority in RUN and FLUSH: mem_busy > branch_taken > load_use_stall > halt_req.
- RUN transitions:
  - mem_busy: freeze the whole pipeline (all writes 0, no flush or bubble); next state MEM_WAIT; wait_cnt=1.
  - branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1. If FLUSH_CYCLES>1, next state FLUSH with flush_cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - load_use_stall: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; stay in RUN. A sustained request stalls on every cycle.
  - halt_req: pc_write=0, if_id_write=0; next state HALTED.
- MEM_WAIT:
  - While mem_busy=1: freeze the pipeline and increment wait_cnt, saturating at 255.
  - When wait_cnt reaches MEM_TIMEOUT with mem_busy still 1: set mem_timeout on that edge. It stays set until reset.
  - In the first cycle with mem_busy=0: evaluate exactly as RUN (same outputs and transitions) and clear wait_cnt.
- FLUSH:
  - Outputs are the same as the RUN branch case: pc_write=1, if_id_flush=1, id_ex_bubble=1.
  - flush_cnt decrements each cycle; go to RUN when it reaches 0.
  - mem_busy during FLUSH freezes the pipeline, holds flush_cnt and stays in FLUSH.
  - A new branch_taken in FLUSH reloads flush_cnt=FLUSH_CYCLES-1.
  - load_use_stall is ignored in FLUSH.
- HALTED: pc_write=if_id_write=ex_mem_write=0, done=1. All inputs are ignored; only reset exits.
- Invariants:
  - if_id_flush and if_id_write=0 are never asserted together.
  - id_ex_bubble=1 never coincides with a frozen pipeline.

Optional Feature:
Macro STALL_STATS_EN.
- Defined: adds output ports load_stall_cnt[15:0], flush_cnt_total[15:0] and mem_wait_cnt[15:0]. These are saturating counters of cycles with load-use bubble, cycles with if_id_flush=1, and frozen mem_busy cycles. They reset to 0 and hold in HALTED.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both cases.

Decomposition:
- Shared package pipeline_ctrl_pkg: enum stall_state_t {RUN, MEM_WAIT, FLUSH, HALTED}; constant NOP_INSTR; localparam widths for flush_cnt (3) and wait_cnt (8).
- One natural sub-module, stall_stat_counters: a saturating counter bank, instantiated only under STALL_STATS_EN.

Test Plan:
- Load-use: load_use_stall=1 for 1 cycle in RUN -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; next cycle defaults.
- Branch with FLUSH_CYCLES=3: branch_taken pulse -> if_id_flush=1 for exactly 3 cycles, then RUN; a simultaneous load_use_stall produces no stall.
- Memory wait: mem_busy=1 for 5 cycles with MEM_TIMEOUT=64 -> all writes 0 for 5 cycles, mem_timeout=0; RUN behaviour on cycle 6.
- Timeout: MEM_TIMEOUT=4, mem_busy held 10 cycles -> mem_timeout rises after the 4th busy cycle and stays 1 after mem_busy drops, until reset.
- Halt: halt_req=1 -> next cycle done=1 and all writes 0; branch_taken and mem_busy then have no effect; reset returns to RUN with outputs at defaults.
- Reset mid-FLUSH (FLUSH_CYCLES=5, reset asserted on the 2nd flush cycle) -> after reset release, defaults with no residual flush. With STALL_STATS_EN, all counters read 0.
